// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer for the E stage.
// Owns HI/LO and models mult/div latency with a busy countdown.
module md_unit_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;
  logic        we_q, we_d;

  logic        is_md, accept;
  logic        is_mul, is_div;
  logic        is_mthi, is_mtlo;
  logic        sdiv;
  logic [63:0] prod;
  logic [31:0] mag_a, mag_b;
  logic [31:0] num, den, quo, rem;
  logic [31:0] div_lo, div_hi;
  logic        neg_q, neg_r;

  assign is_md   = (md_op != 3'd0)
                 && (md_op <= 3'd4);
  assign accept  = start && (state_q == IDLE);
  assign is_mul  = accept && (md_op == 3'd1
                 || md_op == 3'd2);
  assign is_div  = accept && (md_op == 3'd3
                 || md_op == 3'd4);
  assign is_mthi = accept && (md_op == 3'd5);
  assign is_mtlo = accept && (md_op == 3'd6);

  always_comb begin
    prod = '0;
    if (md_op == 3'd1)
      prod = {{32{rs_data[31]}}, rs_data}
           * {{32{rt_data[31]}}, rt_data};
    else
      prod = {32'd0, rs_data}
           * {32'd0, rt_data};
  end

  // Signed divide runs on magnitudes so the
  // 0x80000000 / -1 case cannot overflow.
  assign sdiv  = (md_op == 3'd3);
  assign mag_a = rs_data[31] ? (~rs_data + 32'd1)
                             : rs_data;
  assign mag_b = rt_data[31] ? (~rt_data + 32'd1)
                             : rt_data;
  assign num   = sdiv ? mag_a : rs_data;
  assign den   = sdiv ? mag_b : rt_data;
  assign quo   = (den == 32'd0) ? 32'd0 : num / den;
  assign rem   = (den == 32'd0) ? 32'd0 : num % den;
  assign neg_q = sdiv && (rs_data[31] ^ rt_data[31]);
  assign neg_r = sdiv && rs_data[31];
  assign div_lo = neg_q ? (~quo + 32'd1) : quo;
  assign div_hi = neg_r ? (~rem + 32'd1) : rem;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    we_d    = we_q;
    if (state_q == RUN) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = IDLE;
        if (we_q) begin
          hi_d = phi_q;
          lo_d = plo_q;
        end
      end
    end else begin
      unique case (1'b1)
        is_mul: begin
          phi_d   = prod[63:32];
          plo_d   = prod[31:0];
          we_d    = 1'b1;
          cnt_d   = 4'(MULT_CYCLES);
          state_d = RUN;
        end
        is_div: begin
          phi_d   = div_hi;
          plo_d   = div_lo;
          we_d    = (rt_data != 32'd0);
          cnt_d   = 4'(DIV_CYCLES);
          state_d = RUN;
        end
        is_mthi: hi_d = rs_data;
        is_mtlo: lo_d = rs_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      we_q    <= we_d;
    end
  end

  assign busy      = (cnt_q != 4'd0);
  assign stall_req = busy || (start && is_md);
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Bench for md_unit_ctrl: directed plan plus
// random traffic against a timeline model.
module tb_md_unit_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  md_unit_ctrl #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .busy     (busy),
    .stall_req(stall_req),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  int          edge_n = 0;
  int          m_done = -1;
  logic        m_busy = 1'b0;
  logic        m_we   = 1'b0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [31:0] m_phi  = '0;
  logic [31:0] m_plo  = '0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h @%0t",
                  tag, got, exp, $time);
  endtask

  function automatic void md_ref(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] rh,
    output logic [31:0] rl,
    output logic        we);
    longint          sa, sb, sp, q, r;
    longint unsigned ua, ub, up;
    rh = '0; rl = '0; we = 1'b1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd1: begin
        sp = sa * sb;
        rh = sp[63:32]; rl = sp[31:0];
      end
      3'd2: begin
        up = ua * ub;
        rh = up[63:32]; rl = up[31:0];
      end
      3'd3: begin
        if (b == 0) we = 1'b0;
        else begin
          q = sa / sb; r = sa % sb;
          rl = q[31:0]; rh = r[31:0];
        end
      end
      default: begin
        if (b == 0) we = 1'b0;
        else begin
          up = ua / ub;
          rl = up[31:0];
          up = ua % ub;
          rh = up[31:0];
        end
      end
    endcase
  endfunction

  task automatic step(input logic r,
                      input logic s,
                      input logic [2:0] op,
                      input logic [31:0] a,
                      input logic [31:0] b);
    reset = r; start = s; md_op = op;
    rs_data = a; rt_data = b;
    #1;
    chk("stall_req", {31'd0, stall_req},
        {31'd0, m_busy || (s && op >= 1 && op <= 4)});
    @(posedge clk);
    edge_n++;
    if (r) begin
      m_hi = '0; m_lo = '0;
      m_done = -1; m_we = 1'b0;
    end else begin
      if (m_done == edge_n && m_we) begin
        m_hi = m_phi; m_lo = m_plo;
      end
      if (!m_busy && s) begin
        if (op >= 1 && op <= 4) begin
          md_ref(op, a, b, m_phi, m_plo, m_we);
          m_done = edge_n + ((op <= 2) ? MC : DC);
        end else if (op == 3'd5) m_hi = a;
        else if (op == 3'd6) m_lo = a;
      end
    end
    m_busy = (m_done > edge_n);
    #1;
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 3'd0, $urandom, $urandom);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_op = '0;
    rs_data = '0; rt_data = '0;
    step(1'b1, 1'b0, 3'd0, 0, 0);
    step(1'b1, 1'b1, 3'd1, 5, 7);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);

    step(1'b0, 1'b1, 3'd1, 32'hFFFFFFFE, 32'd3);
    idle(MC);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);

    step(1'b0, 1'b1, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    idle(MC);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);

    step(1'b0, 1'b1, 3'd3, 32'hFFFFFFF9, 32'd2);
    idle(DC);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("div_lo", lo, 32'hFFFFFFFD);
    step(1'b0, 1'b1, 3'd4, 32'd7, 32'd0);
    idle(DC);
    chk("dz_hi", hi, 32'hFFFFFFFF);
    chk("dz_lo", lo, 32'hFFFFFFFD);

    step(1'b0, 1'b1, 3'd5, 32'h12345678, 0);
    step(1'b0, 1'b1, 3'd6, 32'h9ABCDEF0, 0);
    chk("mthi", hi, 32'h12345678);
    chk("mtlo", lo, 32'h9ABCDEF0);
    step(1'b0, 1'b1, 3'd7, 32'h1, 32'h1);
    step(1'b0, 1'b1, 3'd0, 32'h2, 32'h2);

    step(1'b0, 1'b1, 3'd3, 32'd100, 32'd7);
    idle(3);
    step(1'b1, 1'b0, 3'd0, 0, 0);
    idle(DC + 2);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);

    step(1'b0, 1'b1, 3'd1, 32'd3, 32'd4);
    step(1'b0, 1'b1, 3'd1, 32'd5, 32'd6);
    idle(MC);
    chk("ign_lo", lo, 32'd12);
    chk("ign_hi", hi, 32'd0);

    step(1'b0, 1'b1, 3'd3, 32'h80000000, 32'hFFFFFFFF);
    idle(DC);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'd0);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0
        : ($urandom_range(0, 3) == 0)
          ? 32'($urandom_range(1, 9)) : $urandom;
      if ($urandom_range(0, 3) == 0)
        a = 32'($signed(-$urandom_range(0, 99)));
      step($urandom_range(0, 59) == 0,
           1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), a, b);
    end
    idle(DC + 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for the E stage of the 5-stage pipeline.
- Owns the HI/LO registers and models mult/div latency with a busy countdown.
- Raises a stall request so the hazard unit holds D-stage mult/div/mthi/mtlo/mfhi/mflo instructions while the unit is occupied.
- mfhi/mflo read the hi/lo outputs directly; their values are forwarded down the pipeline like ALU results.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu; legal range 1..15.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  E-stage instruction is an md op and E is not flushed; 1-cycle qualifier.
- md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 reserved, treated as none.
- rs_data  in  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source).
- rt_data  in  32  forwarded rt operand (divisor / multiplier).
- busy  out  1  registered; high while a mult/div is in flight.
- stall_req  out  1  combinational: busy OR (start AND md_op in 1..4).
- hi  out  32  registered HI.
- lo  out  32  registered LO.

Behaviour:
- Reset (synchronous, active-high):
  - hi=0, lo=0, busy=0, counter=0, pending results=0.
  - Applies mid-operation: the in-flight result is discarded and HI/LO are not written.
- States:
  - IDLE (counter==0).
  - RUN (counter!=0).
  - busy = (counter!=0), driven from the register.
- IDLE, start=1, md_op mult/multu/div/divu:
  - At that edge: compute the result from rs_data/rt_data and latch it into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Next state RUN.
- RUN:
  - Counter decrements every edge.
  - On the edge where counter goes 1->0: hi<=pending_hi, lo<=pending_lo, return to IDLE.
- Timing:
  - Start accepted at edge E0.
  - busy high during the N cycles following E0.
  - New HI/LO visible in the first cycle after busy falls.
- mult: signed 32x32 -> 64; hi = [63:32], lo = [31:0].
- multu: same as mult, unsigned.
- div:
  - Signed; lo = quotient, truncated toward zero.
  - hi = remainder, which takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient/remainder.
- Divide by zero (rt_data==0, div or divu):
  - Still busy for DIV_CYCLES.
  - HI/LO left unchanged at completion (pending-write enable cleared).
- mthi/mtlo (start=1, md_op 5/6, IDLE):
  - hi or lo <= rs_data at that edge.
  - No busy; stall_req not asserted.
- start while RUN, any op: ignored (hazard unit guarantees it does not occur; the bench checks ignore).
- start with md_op 0 or 7: no effect.
- stall_req is high in the start cycle of a mult/div as well as all busy cycles, so a dependent md instruction in D never issues one cycle early.

Test Plan:
- reset, then start mult rs=0xFFFFFFFE (-2), rt=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001; stall_req high in start cycle plus 5 busy cycles.
- div rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu rs=7, rt=0 -> busy 10 cycles, hi/lo unchanged.
- mthi rs=0x12345678, next cycle mtlo rs=0x9ABCDEF0 -> hi/lo updated one edge after each start; busy never asserts.
- start div, assert reset at busy cycle 4 -> next cycle busy=0, hi=lo=0, no later write occurs. Also: second start mult during busy -> ignored; original result lands on schedule.
- Directed corner: div 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
